// File: rtl/feed_scheduler.sv
// Meal-time scheduler: a prescaled minute-of-day counter is compared against four
// programmable slots and raises timesup until the dispenser opens its food gate.
module feed_scheduler #(
  parameter longint unsigned TICKS_PER_MIN = 64'd3000000000,
  parameter int unsigned     MINS_PER_DAY  = 1440,
  parameter int unsigned     ACK_TIMEOUT   = 1024,
  localparam int             MW            = $clog2(MINS_PER_DAY)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_idx,
  input  logic          cfg_en,
  input  logic [MW-1:0] cfg_minute,
  input  logic          food_gate,
  output logic          timesup,
  output logic          newday,
  output logic [MW-1:0] minute_of_day,
  output logic          meal_pending,
  output logic [3:0]    missed_count
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int WW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [MW-1:0] MIN_LAST   = MW'(MINS_PER_DAY - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } state_t;

  logic [PW-1:0] presc_q;
  logic [MW-1:0] minute_q;
  logic          newday_q;
  logic          upd_q;
  logic          match_q;
  logic          tick;
  logic [3:0]    hit_vec;

  state_t        state_q;
  logic          timesup_q;
  logic          pending_q;
  logic [WW-1:0] wait_q;
  logic [3:0]    missed_q;

  logic          busy_miss;
  logic          timeout_miss;
  logic [1:0]    miss_inc;
  logic [4:0]    miss_sum;
  logic [3:0]    missed_d;

  assign tick = (presc_q == PRESC_LAST);

  // Each slot holds its own enable/minute; minutes >= MINS_PER_DAY can never equal minute_q.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic          en_q;
      logic [MW-1:0] min_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          en_q  <= 1'b0;
          min_q <= '0;
        end else if (cfg_we && (cfg_idx == 2'(gi))) begin
          en_q  <= cfg_en;
          min_q <= cfg_minute;
        end
      end

      assign hit_vec[gi] = en_q && (min_q == minute_q);
    end
  endgenerate

  // upd_q marks the first cycle showing a new minute; the match is registered one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      minute_q <= '0;
      newday_q <= 1'b0;
      upd_q    <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      presc_q  <= tick ? '0 : presc_q + 1'b1;
      upd_q    <= tick;
      newday_q <= tick && (minute_q == MIN_LAST);
      match_q  <= upd_q && (|hit_vec);
      if (tick) begin
        minute_q <= (minute_q == MIN_LAST) ? '0 : minute_q + 1'b1;
      end
    end
  end

  // A timeout and a dropped match can land in the same cycle, so up to two misses are added.
  always_comb begin
    busy_miss    = match_q && (state_q != IDLE) && pending_q;
    timeout_miss = (state_q == REQ) && !food_gate && (wait_q == WAIT_LAST);
    miss_inc     = {1'b0, busy_miss} + {1'b0, timeout_miss};
    miss_sum     = {1'b0, (newday_q ? 4'd0 : missed_q)} + {3'b000, miss_inc};
    missed_d     = miss_sum[4] ? 4'hF : miss_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timesup_q <= 1'b0;
      pending_q <= 1'b0;
      wait_q    <= '0;
      missed_q  <= '0;
    end else begin
      missed_q <= missed_d;
      case (state_q)
        IDLE: begin
          wait_q    <= '0;
          timesup_q <= 1'b0;
          if (match_q) begin
            state_q   <= REQ;
            timesup_q <= 1'b1;
          end else if (pending_q) begin
            pending_q <= 1'b0;
            state_q   <= REQ;
            timesup_q <= 1'b1;
          end
        end
        REQ: begin
          wait_q <= wait_q + 1'b1;
          if (food_gate) begin
            state_q   <= SERVE;
            timesup_q <= 1'b0;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= IDLE;
            timesup_q <= 1'b0;
          end
          if (match_q && !pending_q) pending_q <= 1'b1;
        end
        SERVE: begin
          timesup_q <= 1'b0;
          if (!food_gate) state_q <= IDLE;
          if (match_q && !pending_q) pending_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          timesup_q <= 1'b0;
        end
      endcase
    end
  end

  assign timesup       = timesup_q;
  assign newday        = newday_q;
  assign minute_of_day = minute_q;
  assign meal_pending  = pending_q;
  assign missed_count  = missed_q;

endmodule

// File: tb/tb_feed_scheduler.sv
// Bench for feed_scheduler: directed scenarios push expected requests into a queue,
// and a monitor scores each timesup pulse as it completes.
module tb_feed_scheduler;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = 2'd0;
  logic          cfg_en = 1'b0;
  logic [MW-1:0] cfg_minute = '0;
  logic          food_gate = 1'b0;
  logic          timesup;
  logic          newday;
  logic [MW-1:0] minute_of_day;
  logic          meal_pending;
  logic [3:0]    missed_count;

  feed_scheduler #(
    .TICKS_PER_MIN(4),
    .MINS_PER_DAY (16),
    .ACK_TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_en       (cfg_en),
    .cfg_minute   (cfg_minute),
    .food_gate    (food_gate),
    .timesup      (timesup),
    .newday       (newday),
    .minute_of_day(minute_of_day),
    .meal_pending (meal_pending),
    .missed_count (missed_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rises = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int minute;
    int lat;
    int dur;
    int miss;
  } txn_t;

  txn_t exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input int m, input int l, input int d, input int ms);
    txn_t t;
    t.minute = m;
    t.lat    = l;
    t.dur    = d;
    t.miss   = ms;
    exp_q.push_back(t);
  endtask

  // Monitor: one transaction per timesup pulse, scored when the pulse ends.
  logic          ts_prev;
  logic [MW-1:0] min_prev;
  int            last_chg;
  int            rise_cyc;
  int            rise_min;
  int            rise_lat;

  initial begin
    txn_t e;
    ts_prev  = 1'b0;
    min_prev = '0;
    last_chg = 0;
    rise_cyc = 0;
    rise_min = 0;
    rise_lat = 0;
    forever begin
      @(negedge clk);
      if (minute_of_day != min_prev) last_chg = cyc;
      min_prev = minute_of_day;
      if (timesup && !ts_prev) begin
        rise_cyc = cyc;
        rise_min = int'(minute_of_day);
        rise_lat = cyc - last_chg;
        rises++;
      end
      if (!timesup && ts_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_request_minute", rise_min, -1);
        end else begin
          e = exp_q.pop_front();
          $display("txn: req minute=%0d lat=%0d dur=%0d missed=%0d", rise_min, rise_lat,
                   cyc - rise_cyc, missed_count);
          chk("req_minute", rise_min, e.minute);
          chk("req_latency", rise_lat, e.lat);
          chk("req_duration", cyc - rise_cyc, e.dur);
          chk("req_missed_after", int'(missed_count), e.miss);
        end
      end
      ts_prev = timesup;
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_slot(input int idx, input bit en, input int m);
    @(negedge clk);
    cfg_we     = 1'b1;
    cfg_idx    = idx[1:0];
    cfg_en     = en;
    cfg_minute = m[MW-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_ts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (timesup) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_timesup", int'(timesup), 1);
  endtask

  task automatic wait_min(input int m);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (int'(minute_of_day) == m) break;
    end
    chk("wait_minute", int'(minute_of_day), m);
  endtask

  task automatic wait_newday();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (newday) break;
    end
    chk("wait_newday", int'(newday), 1);
  endtask

  initial begin
    bit ok;
    int r0;

    // 1: reset values and free-running minute counter
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_timesup", int'(timesup), 0);
    chk("rst_newday", int'(newday), 0);
    chk("rst_minute", int'(minute_of_day), 0);
    chk("rst_pending", int'(meal_pending), 0);
    chk("rst_missed", int'(missed_count), 0);
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("count_minute", int'(minute_of_day), (k / 4) % 16);
      chk("count_newday", int'(newday), (k == 64) ? 1 : 0);
    end

    // 2: acknowledged meal at minute 3
    do_reset(2);
    write_slot(0, 1'b1, 3);
    push_exp(3, 2, 3, 0);
    wait_ts(ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      food_gate = 1'b1;
      repeat (5) @(negedge clk);
      food_gate = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("ack_timesup_idle", int'(timesup), 0);
    chk("ack_missed", int'(missed_count), 0);
    chk("ack_pending", int'(meal_pending), 0);

    // 3: timeout at minute 5, cleared at day wrap
    do_reset(2);
    write_slot(1, 1'b1, 5);
    push_exp(5, 2, 8, 1);
    wait_min(15);
    chk("timeout_missed", int'(missed_count), 1);
    wait_newday();
    repeat (2) @(negedge clk);
    chk("newday_clears_missed", int'(missed_count), 0);

    // 4: back-to-back meals at 6, 7, 8
    do_reset(2);
    write_slot(0, 1'b1, 6);
    write_slot(1, 1'b1, 7);
    write_slot(2, 1'b1, 8);
    push_exp(6, 2, 1, 0);
    push_exp(12, 0, 8, 2);
    wait_ts(ok);
    food_gate = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) chk("b2b_pending_set", int'(meal_pending), 1);
      if (i == 10) chk("b2b_missed_one", int'(missed_count), 1);
      if (i == 20) chk("b2b_pending_held", int'(meal_pending), 1);
    end
    food_gate = 1'b0;
    wait_min(14);
    chk("b2b_pending_cleared", int'(meal_pending), 0);
    chk("b2b_missed_final", int'(missed_count), 2);

    // 5: duplicate slots at minute 0
    do_reset(2);
    write_slot(2, 1'b1, 0);
    write_slot(3, 1'b1, 0);
    push_exp(0, 2, 1, 0);
    r0 = rises;
    wait_newday();
    @(negedge clk);
    chk("newday_single_pulse", int'(newday), 0);
    wait_ts(ok);
    food_gate = 1'b1;
    @(negedge clk);
    chk("dup_pending", int'(meal_pending), 0);
    food_gate = 1'b0;
    repeat (12) @(negedge clk);
    chk("dup_single_request", rises - r0, 1);

    // 6a: reset while requesting
    do_reset(2);
    write_slot(0, 1'b1, 2);
    push_exp(2, 2, 1, 0);
    wait_ts(ok);
    reset = 1'b1;
    @(negedge clk);
    chk("midreq_timesup", int'(timesup), 0);
    chk("midreq_missed", int'(missed_count), 0);
    chk("midreq_minute", int'(minute_of_day), 0);
    reset = 1'b0;
    r0 = rises;
    repeat (40) @(negedge clk);
    chk("midreq_slots_cleared", rises - r0, 0);

    // 6b: disable a slot one minute before it matches
    do_reset(2);
    write_slot(1, 1'b1, 3);
    wait_min(2);
    write_slot(1, 1'b0, 3);
    r0 = rises;
    wait_min(5);
    chk("disabled_slot_silent", rises - r0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
